id_ex_issue: RTL and testbench

//  ID/EX pipeline stage directly upstream of the ALU. Registers decoded ID fields and

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/id_ex_issue_if.sv | 58 +++++
 rtl/fwd_sel.sv | 33 +++
 rtl/id_ex_issue.sv | 100 ++++++++++
 tb/tb_id_ex_issue.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the ID/EX issue stage.
//   - ALU control encodings driven to the ALU.
//   - ALUOp codes produced by the main decoder.
//   - {funct7,funct3} patterns recognised for R-type operations.
//   - Bit positions inside the 4-bit control bundle.
//   - alu_decode(): ALUOp/funct to ALU control translation.
package cpu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [9:0] FUNCT_AND = 10'b0000000_111;
  localparam logic [9:0] FUNCT_OR  = 10'b0000000_110;
  localparam logic [9:0] FUNCT_ADD = 10'b0000000_000;
  localparam logic [9:0] FUNCT_SUB = 10'b0100000_000;
  localparam logic [9:0] FUNCT_MUL = 10'b0000001_000;

  // Control bundle layout: {RegWrite, MemRead, MemWrite, MemtoReg}
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  // Unrecognised R-type functs fall back to ADD rather than trapping.
  function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                            input logic [9:0] funct);
    logic [2:0] ctl;
    ctl = ALU_ADD;
    case (aluop)
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_AND: ctl = ALU_AND;
          FUNCT_OR:  ctl = ALU_OR;
          FUNCT_ADD: ctl = ALU_ADD;
          FUNCT_SUB: ctl = ALU_SUB;
          FUNCT_MUL: ctl = ALU_MUL;
          default:   ctl = ALU_ADD;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/id_ex_issue_if.sv
// id_ex_issue_if: bundles every non-clock/reset signal of the ID/EX stage.
//   Pipeline control : stall_i, flush_i
//   ID side          : id_* decoded fields and register-file read data
//   Forward sources  : exm_* (EX/MEM), wb_* (MEM/WB)
//   EX side outputs  : hazard_o, valid_o, data1_o, data2_o, ALUCtrl_o,
//                      store_data_o, rd_o, ctrl_o
// Modports: master = surrounding pipeline (drives *_i), slave = the stage.
interface id_ex_issue_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  logic               stall_i;
  logic               flush_i;
  logic               id_valid_i;
  logic [DATA_W-1:0]  id_rs1_data_i;
  logic [DATA_W-1:0]  id_rs2_data_i;
  logic [DATA_W-1:0]  id_imm_i;
  logic [RADDR_W-1:0] id_rs1_i;
  logic [RADDR_W-1:0] id_rs2_i;
  logic [RADDR_W-1:0] id_rd_i;
  logic [9:0]         id_funct_i;
  logic [1:0]         id_aluop_i;
  logic               id_alusrc_i;
  logic [3:0]         id_ctrl_i;
  logic [RADDR_W-1:0] exm_rd_i;
  logic               exm_regwrite_i;
  logic [DATA_W-1:0]  exm_data_i;
  logic [RADDR_W-1:0] wb_rd_i;
  logic               wb_regwrite_i;
  logic [DATA_W-1:0]  wb_data_i;

  logic               hazard_o;
  logic               valid_o;
  logic [DATA_W-1:0]  data1_o;
  logic [DATA_W-1:0]  data2_o;
  logic [2:0]         ALUCtrl_o;
  logic [DATA_W-1:0]  store_data_o;
  logic [RADDR_W-1:0] rd_o;
  logic [3:0]         ctrl_o;

  modport master (
    output stall_i, flush_i, id_valid_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_funct_i, id_aluop_i, id_alusrc_i,
           id_ctrl_i, exm_rd_i, exm_regwrite_i, exm_data_i, wb_rd_i,
           wb_regwrite_i, wb_data_i,
    input  hazard_o, valid_o, data1_o, data2_o, ALUCtrl_o, store_data_o, rd_o,
           ctrl_o
  );

  modport slave (
    input  stall_i, flush_i, id_valid_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_funct_i, id_aluop_i, id_alusrc_i,
           id_ctrl_i, exm_rd_i, exm_regwrite_i, exm_data_i, wb_rd_i,
           wb_regwrite_i, wb_data_i,
    output hazard_o, valid_o, data1_o, data2_o, ALUCtrl_o, store_data_o, rd_o,
           ctrl_o
  );
endinterface

// File: rtl/fwd_sel.sv
// fwd_sel: combinational 3:1 operand select for one ALU source.
//   rs           : source register address held in ID/EX
//   rf_data      : register-file value captured with the instruction
//   exm_*        : youngest in-flight result (EX/MEM)
//   wb_*         : older in-flight result (MEM/WB)
//   data         : selected operand
// The younger EX/MEM result is checked first so it wins on a dual match;
// x0 is hard-wired zero and is never forwarded.
module fwd_sel #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] rs,
  input  logic [DATA_W-1:0]  rf_data,
  input  logic [RADDR_W-1:0] exm_rd,
  input  logic               exm_regwrite,
  input  logic [DATA_W-1:0]  exm_data,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic               wb_regwrite,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [DATA_W-1:0]  data
);

  always_comb begin
    data = rf_data;
    if (exm_regwrite && (exm_rd != '0) && (exm_rd == rs)) begin
      data = exm_data;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs)) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_issue.sv
// id_ex_issue: ID/EX pipeline register feeding the ALU.
//   clk_i  : clock, all state on the rising edge
//   rst_i  : synchronous reset, active low
//   bus    : id_ex_issue_if.slave carrying pipeline control, ID fields,
//            forwarding sources and all EX-side outputs.
// Captures decoded ID fields (translating ALUOp/funct to ALU control at
// capture), forwards in-flight results into both operands, and detects
// load-use hazards, inserting a bubble while ID is held.
// Edge priority: reset > flush > stall > hazard bubble > load.
module id_ex_issue
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  id_ex_issue_if.slave bus
);

  logic               valid_reg;
  logic [3:0]         ctrl_reg;
  logic [RADDR_W-1:0] rd_reg;
  logic [RADDR_W-1:0] rs_reg      [2];
  logic [DATA_W-1:0]  rs_data_reg [2];
  logic [DATA_W-1:0]  imm_reg;
  logic               alusrc_reg;
  logic [2:0]         aluctrl_reg;

  logic               hazard;
  logic [DATA_W-1:0]  fwd_data [2];

  // Load in EX whose destination is read by the instruction now in ID:
  // the loaded value is not available for forwarding until next cycle.
  assign hazard = valid_reg && ctrl_reg[CTRL_MEMREAD] && (rd_reg != '0) &&
                  bus.id_valid_i &&
                  ((rd_reg == bus.id_rs1_i) || (rd_reg == bus.id_rs2_i));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_reg      <= 1'b0;
      ctrl_reg       <= '0;
      rd_reg         <= '0;
      rs_reg[0]      <= '0;
      rs_reg[1]      <= '0;
      rs_data_reg[0] <= '0;
      rs_data_reg[1] <= '0;
      imm_reg        <= '0;
      alusrc_reg     <= 1'b0;
      aluctrl_reg    <= ALU_AND;
    end else if (bus.flush_i || (!bus.stall_i && hazard)) begin
      // Bubble: only the fields that can cause side effects are cleared.
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      rd_reg    <= '0;
    end else if (!bus.stall_i) begin
      valid_reg      <= bus.id_valid_i;
      ctrl_reg       <= bus.id_ctrl_i;
      rd_reg         <= bus.id_rd_i;
      rs_reg[0]      <= bus.id_rs1_i;
      rs_reg[1]      <= bus.id_rs2_i;
      rs_data_reg[0] <= bus.id_rs1_data_i;
      rs_data_reg[1] <= bus.id_rs2_data_i;
      imm_reg        <= bus.id_imm_i;
      alusrc_reg     <= bus.id_alusrc_i;
      aluctrl_reg    <= alu_decode(bus.id_aluop_i, bus.id_funct_i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_sel #(
        .DATA_W (DATA_W),
        .RADDR_W(RADDR_W)
      ) u_fwd_sel (
        .rs          (rs_reg[gi]),
        .rf_data     (rs_data_reg[gi]),
        .exm_rd      (bus.exm_rd_i),
        .exm_regwrite(bus.exm_regwrite_i),
        .exm_data    (bus.exm_data_i),
        .wb_rd       (bus.wb_rd_i),
        .wb_regwrite (bus.wb_regwrite_i),
        .wb_data     (bus.wb_data_i),
        .data        (fwd_data[gi])
      );
    end
  endgenerate

  assign bus.hazard_o     = hazard;
  assign bus.valid_o      = valid_reg;
  assign bus.data1_o      = fwd_data[0];
  assign bus.data2_o      = alusrc_reg ? imm_reg : fwd_data[1];
  assign bus.store_data_o = fwd_data[1];
  assign bus.ALUCtrl_o    = aluctrl_reg;
  assign bus.rd_o         = rd_reg;
  // Bubbles must never write the register file or memory.
  assign bus.ctrl_o       = valid_reg ? ctrl_reg : 4'b0000;

endmodule

// File: tb/tb_id_ex_issue.sv
// tb_id_ex_issue: directed scenarios followed by randomized traffic, every
// cycle compared against a transaction-level model of the EX slot.
module tb_id_ex_issue;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_issue_if bus ();

  id_ex_issue dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model of the instruction sitting in EX.
  typedef struct {
    bit        valid;
    bit [3:0]  ctrl;
    bit [4:0]  rd;
    bit [4:0]  rs1;
    bit [4:0]  rs2;
    bit [31:0] rf1;
    bit [31:0] rf2;
    bit [31:0] imm;
    bit        alusrc;
    bit [2:0]  op;
  } ex_t;

  ex_t m;

  function automatic bit [2:0] ref_alu(input bit [1:0] aluop, input bit [9:0] funct);
    bit [6:0] f7;
    bit [2:0] f3;
    f7 = funct[9:3];
    f3 = funct[2:0];
    if (aluop == 2'd1) return 3'b110;
    if (aluop != 2'd2) return 3'b010;
    if (f7 == 7'd0 && f3 == 3'd7) return 3'b000;
    if (f7 == 7'd0 && f3 == 3'd6) return 3'b001;
    if (f7 == 7'h20 && f3 == 3'd0) return 3'b110;
    if (f7 == 7'd1 && f3 == 3'd0) return 3'b011;
    return 3'b010;
  endfunction

  function automatic bit [31:0] ref_fwd(input bit [4:0] rs, input bit [31:0] rf);
    if (bus.exm_regwrite_i && bus.exm_rd_i != 0 && bus.exm_rd_i == rs) return bus.exm_data_i;
    if (bus.wb_regwrite_i && bus.wb_rd_i != 0 && bus.wb_rd_i == rs) return bus.wb_data_i;
    return rf;
  endfunction

  function automatic bit ref_hazard();
    return m.valid && m.ctrl[2] && m.rd != 0 && bus.id_valid_i &&
           (m.rd == bus.id_rs1_i || m.rd == bus.id_rs2_i);
  endfunction

  task automatic clear_inputs();
    bus.stall_i = 0; bus.flush_i = 0; bus.id_valid_i = 0;
    bus.id_rs1_data_i = 0; bus.id_rs2_data_i = 0; bus.id_imm_i = 0;
    bus.id_rs1_i = 0; bus.id_rs2_i = 0; bus.id_rd_i = 0; bus.id_funct_i = 0;
    bus.id_aluop_i = 0; bus.id_alusrc_i = 0; bus.id_ctrl_i = 0;
    bus.exm_rd_i = 0; bus.exm_regwrite_i = 0; bus.exm_data_i = 0;
    bus.wb_rd_i = 0; bus.wb_regwrite_i = 0; bus.wb_data_i = 0;
  endtask

  // Called shortly after a falling edge with inputs driven: compares the
  // outputs to the model, crosses one rising edge, advances the model.
  task automatic step();
    bit haz;
    bit [31:0] f2;
    #1;
    haz = ref_hazard();
    f2  = ref_fwd(m.rs2, m.rf2);
    check_val("valid", bus.valid_o, m.valid);
    check_val("ctrl", bus.ctrl_o, m.valid ? m.ctrl : 4'd0);
    check_val("rd", bus.rd_o, m.rd);
    check_val("hazard", bus.hazard_o, haz);
    if (m.valid) begin
      check_val("aluctrl", bus.ALUCtrl_o, m.op);
      check_val("data1", bus.data1_o, ref_fwd(m.rs1, m.rf1));
      check_val("data2", bus.data2_o, m.alusrc ? m.imm : f2);
      check_val("store", bus.store_data_o, f2);
    end
    $display("cyc %0d rst=%0b stall=%0b flush=%0b haz=%0b valid=%0b rd=%0d ctrl=%h",
             cyc, rst, bus.stall_i, bus.flush_i, bus.hazard_o, bus.valid_o, bus.rd_o, bus.ctrl_o);
    @(posedge clk);
    if (!rst) begin
      m = '{default: 0};
    end else if (bus.flush_i || (!bus.stall_i && haz)) begin
      m.valid = 0; m.ctrl = 0; m.rd = 0;
    end else if (!bus.stall_i) begin
      m.valid  = bus.id_valid_i;
      m.ctrl   = bus.id_ctrl_i;
      m.rd     = bus.id_rd_i;
      m.rs1    = bus.id_rs1_i;
      m.rs2    = bus.id_rs2_i;
      m.rf1    = bus.id_rs1_data_i;
      m.rf2    = bus.id_rs2_data_i;
      m.imm    = bus.id_imm_i;
      m.alusrc = bus.id_alusrc_i;
      m.op     = ref_alu(bus.id_aluop_i, bus.id_funct_i);
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    m = '{default: 0};
    rst = 0;
    clear_inputs();
    @(negedge clk);

    // 1. Reset with a valid instruction offered
    bus.id_valid_i = 1; bus.id_ctrl_i = 4'b1100; bus.id_rd_i = 5'd3; bus.id_rs1_i = 5'd3;
    step(); step();
    check_val("rst_valid", bus.valid_o, 1'b0);
    check_val("rst_ctrl", bus.ctrl_o, 4'b0000);
    check_val("rst_aluctrl", bus.ALUCtrl_o, 3'b000);
    check_val("rst_hazard", bus.hazard_o, 1'b0);
    rst = 1;

    // 2. R-type SUB then MUL, no forwarding
    clear_inputs();
    bus.id_valid_i = 1; bus.id_aluop_i = 2'b10; bus.id_funct_i = 10'b0100000_000;
    bus.id_rs1_i = 5'd5; bus.id_rs1_data_i = 32'd9; bus.id_rs2_i = 5'd3; bus.id_rs2_data_i = 32'd3;
    bus.id_rd_i = 5'd7; bus.id_ctrl_i = 4'b1000;
    step();
    check_val("sub_aluctrl", bus.ALUCtrl_o, 3'b110);
    check_val("sub_data1", bus.data1_o, 32'd9);
    check_val("sub_data2", bus.data2_o, 32'd3);
    bus.id_funct_i = 10'b0000001_000;
    step();
    check_val("mul_aluctrl", bus.ALUCtrl_o, 3'b011);

    // 3. Forwarding priority on rs1 = x4
    clear_inputs();
    bus.id_valid_i = 1; bus.id_rs1_i = 5'd4; bus.id_rs1_data_i = 32'h33; bus.id_rd_i = 5'd10;
    bus.id_ctrl_i = 4'b1000;
    step();
    bus.exm_rd_i = 5'd4; bus.exm_regwrite_i = 1; bus.exm_data_i = 32'h11;
    bus.wb_rd_i = 5'd4; bus.wb_regwrite_i = 1; bus.wb_data_i = 32'h22;
    #1 check_val("fwd_both", bus.data1_o, 32'h11);
    bus.exm_regwrite_i = 0;
    #1 check_val("fwd_wb", bus.data1_o, 32'h22);
    bus.wb_rd_i = 5'd0; bus.exm_rd_i = 5'd0; bus.exm_regwrite_i = 1;
    #1 check_val("fwd_x0", bus.data1_o, 32'h33);

    // 4. Load-use: lw x6 in EX, ID reads x6 via rs2
    clear_inputs();
    bus.id_valid_i = 1; bus.id_rd_i = 5'd6; bus.id_ctrl_i = 4'b1101; bus.id_rs1_i = 5'd2;
    step();
    bus.id_rs1_i = 5'd1; bus.id_rs2_i = 5'd6; bus.id_rd_i = 5'd8; bus.id_ctrl_i = 4'b1000;
    bus.id_aluop_i = 2'b10;
    #1 check_val("lu_hazard", bus.hazard_o, 1'b1);
    step();
    check_val("lu_bubble_valid", bus.valid_o, 1'b0);
    check_val("lu_bubble_ctrl", bus.ctrl_o, 4'b0000);
    step();
    check_val("lu_capture_valid", bus.valid_o, 1'b1);
    check_val("lu_capture_rd", bus.rd_o, 5'd8);

    // 5. Stall holds for 3 cycles, then flush beats stall
    bus.stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      bus.id_rd_i = 5'(11 + i); bus.id_rs1_data_i = $urandom; bus.id_funct_i = 10'(i);
      step();
      check_val("stall_rd", bus.rd_o, 5'd8);
      check_val("stall_valid", bus.valid_o, 1'b1);
    end
    bus.flush_i = 1;
    step();
    check_val("flush_stall_valid", bus.valid_o, 1'b0);

    // 6. addi with immediate; rs2 forwarded to store data only
    clear_inputs();
    bus.id_valid_i = 1; bus.id_aluop_i = 2'b11; bus.id_alusrc_i = 1; bus.id_imm_i = 32'hFFFF_FFFC;
    bus.id_rs1_i = 5'd1; bus.id_rs2_i = 5'd7; bus.id_rs2_data_i = 32'h99; bus.id_rd_i = 5'd9;
    bus.id_ctrl_i = 4'b1000;
    step();
    bus.exm_rd_i = 5'd7; bus.exm_regwrite_i = 1; bus.exm_data_i = 32'h7;
    #1;
    check_val("addi_data2", bus.data2_o, 32'hFFFF_FFFC);
    check_val("addi_store", bus.store_data_o, 32'h7);
    check_val("addi_aluctrl", bus.ALUCtrl_o, 3'b010);

    // Reset while stalled clears the stage
    bus.stall_i = 1; rst = 0;
    step();
    check_val("rst_stall_valid", bus.valid_o, 1'b0);
    rst = 1;

    // Randomized traffic, small register range so matches are frequent
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 49) != 0);
      bus.flush_i = ($urandom_range(0, 9) == 0);
      bus.stall_i = ($urandom_range(0, 5) == 0);
      bus.id_valid_i = ($urandom_range(0, 3) != 0);
      bus.id_rs1_i = 5'($urandom_range(0, 7));
      bus.id_rs2_i = 5'($urandom_range(0, 7));
      bus.id_rd_i = 5'($urandom_range(0, 7));
      bus.id_rs1_data_i = $urandom;
      bus.id_rs2_data_i = $urandom;
      bus.id_imm_i = $urandom;
      case ($urandom_range(0, 5))
        0: bus.id_funct_i = 10'b0000000_111;
        1: bus.id_funct_i = 10'b0000000_110;
        2: bus.id_funct_i = 10'b0000000_000;
        3: bus.id_funct_i = 10'b0100000_000;
        4: bus.id_funct_i = 10'b0000001_000;
        default: bus.id_funct_i = 10'($urandom);
      endcase
      bus.id_aluop_i = 2'($urandom);
      bus.id_alusrc_i = 1'($urandom);
      bus.id_ctrl_i = 4'($urandom);
      bus.exm_rd_i = 5'($urandom_range(0, 7));
      bus.exm_regwrite_i = 1'($urandom);
      bus.exm_data_i = $urandom;
      bus.wb_rd_i = 5'($urandom_range(0, 7));
      bus.wb_regwrite_i = 1'($urandom);
      bus.wb_data_i = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
